shortest_path_4: RTL and testbench

- All-pairs shortest-path engine implementing Floyd-Warshall over an N×N matrix of 8-bit edge weights.
- Reads the input matrix from external SRAM M, iterates in work SRAM L, and writes the result matrix to SRAM P.
- Each SRAM is a dual-port synchronous memory: the engine owns the 8-bit A ports, and the host uses the 32-bit B ports for load and readback.
- Started by a Go pulse; signals completion with Done.

---
 rtl/shortest_path_4.sv | 276 +++++++++++++++++++++++++++
 tb/tb_shortest_path_4.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/shortest_path_4.sv
// shortest_path_4 : all-pairs shortest path (Floyd-Warshall) over an N x N
// matrix of saturating D_WIDTH-bit weights. Copies M -> L, relaxes in L,
// then copies L -> P. Optional build macro INF_SKIP_EN skips the whole j loop
// of a (k,i) pair whose dik is INF; results are identical, only faster.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | waiting for Go, no memory traffic
// S_CI_RD    | M read of element a on the bus
// S_CI_CAP   | M data valid: queue L write of a, queue M read of a+1
// S_R_IK     | queue L read of (i,k)
// S_R_IK_RD  | L read of (i,k) on the bus
// S_R_IK_DAT | dik valid: latch it (or skip the row when INF_SKIP_EN)
// S_R_J      | queue L read of (k,j); any pending write lands this cycle
// S_R_KJ_RD  | L read of (k,j) on the bus, queue read of (i,j)
// S_R_IJ_RD  | L read of (i,j) on the bus, dkj valid: latch it
// S_R_CMP    | dij valid: queue write of saturated sum if smaller, step j
// S_CO_ST    | queue L read of element 0 for the copy-out
// S_CO_RD    | L read of element a on the bus
// S_CO_CAP   | L data valid: queue P write of a, queue L read of a+1
// S_CO_FIN   | last P write on the bus, raise Done next
// S_DONE     | Done held high, no memory traffic, Go restarts
module shortest_path_4 #(
  parameter int                 N       = 64,
  parameter int                 A_WIDTH = 13,
  parameter int                 D_WIDTH = 8,
  parameter logic [D_WIDTH-1:0] INF     = {D_WIDTH{1'b1}}
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Go,
  input  logic [D_WIDTH-1:0] L_In,
  input  logic [D_WIDTH-1:0] M_In,
  output logic [D_WIDTH-1:0] L_Out,
  output logic [D_WIDTH-1:0] P_Out,
  output logic [A_WIDTH-1:0] M_Addr,
  output logic [A_WIDTH-1:0] L_Addr,
  output logic [A_WIDTH-1:0] P_Addr,
  output logic               M_En,
  output logic               M_We,
  output logic               L_En,
  output logic               L_We,
  output logic               P_En,
  output logic               P_We,
  output logic               Done
);

  localparam int                 CW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [A_WIDTH-1:0] LAST_A = A_WIDTH'(N * N - 1);
  localparam logic [CW-1:0]      LAST_C = CW'(N - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CI_RD, S_CI_CAP, S_R_IK, S_R_IK_RD, S_R_IK_DAT, S_R_J,
    S_R_KJ_RD, S_R_IJ_RD, S_R_CMP, S_CO_ST, S_CO_RD, S_CO_CAP, S_CO_FIN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [A_WIDTH-1:0]   a_q, a_d;
  logic [CW-1:0]        k_q, k_d, i_q, i_d, j_q, j_d;
  logic [D_WIDTH-1:0]   dik_q, dik_d, dkj_q, dkj_d;
  logic                 m_en_q, m_en_d, l_en_q, l_en_d, l_we_q, l_we_d;
  logic                 p_en_q, p_en_d, p_we_q, p_we_d, done_q, done_d;
  logic [A_WIDTH-1:0]   m_addr_q, m_addr_d, l_addr_q, l_addr_d;
  logic [A_WIDTH-1:0]   p_addr_q, p_addr_d;
  logic [D_WIDTH-1:0]   l_out_q, l_out_d, p_out_q, p_out_d;

  logic [D_WIDTH:0]     sum_w;
  logic [D_WIDTH-1:0]   s_sat;
  logic                 last_i, last_k, relax_end, skip_ik;
  logic [CW-1:0]        i_nxt, k_nxt;

  function automatic logic [A_WIDTH-1:0] idx(input logic [CW-1:0] r,
                                             input logic [CW-1:0] c);
    return A_WIDTH'(r) * A_WIDTH'(N) + A_WIDTH'(c);
  endfunction

  // Saturating candidate distance and i/k loop stepping shared by RELAX states
  always_comb begin
    sum_w     = {1'b0, dik_q} + {1'b0, dkj_q};
    s_sat     = sum_w[D_WIDTH-1:0];
    if (dik_q == INF || dkj_q == INF || sum_w >= {1'b0, INF}) s_sat = INF;
    last_i    = (i_q == LAST_C);
    last_k    = (k_q == LAST_C);
    relax_end = last_i && last_k;
    i_nxt     = last_i ? '0 : i_q + 1'b1;
    k_nxt     = last_i ? (last_k ? '0 : k_q + 1'b1) : k_q;
`ifdef INF_SKIP_EN
    skip_ik   = (L_In == INF);
`else
    skip_ik   = 1'b0;
`endif
  end

  // Next-state and next-output logic; enables default to a single-cycle pulse
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    k_d      = k_q;
    i_d      = i_q;
    j_d      = j_q;
    dik_d    = dik_q;
    dkj_d    = dkj_q;
    m_en_d   = 1'b0;
    m_addr_d = m_addr_q;
    l_en_d   = 1'b0;
    l_we_d   = 1'b0;
    l_addr_d = l_addr_q;
    l_out_d  = l_out_q;
    p_en_d   = 1'b0;
    p_we_d   = 1'b0;
    p_addr_d = p_addr_q;
    p_out_d  = p_out_q;
    done_d   = done_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Go) begin
          done_d   = 1'b0;
          a_d      = '0;
          k_d      = '0;
          i_d      = '0;
          j_d      = '0;
          m_en_d   = 1'b1;
          m_addr_d = '0;
          state_d  = S_CI_RD;
        end
      end
      S_CI_RD: state_d = S_CI_CAP;
      S_CI_CAP: begin
        l_en_d   = 1'b1;
        l_we_d   = 1'b1;
        l_addr_d = a_q;
        l_out_d  = M_In;
        if (a_q == LAST_A) begin
          state_d = S_R_IK;
        end else begin
          a_d      = a_q + 1'b1;
          m_en_d   = 1'b1;
          m_addr_d = a_q + 1'b1;
          state_d  = S_CI_RD;
        end
      end
      S_R_IK: begin
        l_en_d   = 1'b1;
        l_addr_d = idx(i_q, k_q);
        state_d  = S_R_IK_RD;
      end
      S_R_IK_RD: state_d = S_R_IK_DAT;
      S_R_IK_DAT: begin
        dik_d = L_In;
        if (skip_ik) begin
          i_d     = i_nxt;
          k_d     = k_nxt;
          a_d     = '0;
          state_d = relax_end ? S_CO_ST : S_R_IK;
        end else begin
          state_d = S_R_J;
        end
      end
      S_R_J: begin
        l_en_d   = 1'b1;
        l_addr_d = idx(k_q, j_q);
        state_d  = S_R_KJ_RD;
      end
      S_R_KJ_RD: begin
        l_en_d   = 1'b1;
        l_addr_d = idx(i_q, j_q);
        state_d  = S_R_IJ_RD;
      end
      S_R_IJ_RD: begin
        dkj_d   = L_In;
        state_d = S_R_CMP;
      end
      S_R_CMP: begin
        if (s_sat < L_In) begin
          l_en_d   = 1'b1;
          l_we_d   = 1'b1;
          l_addr_d = idx(i_q, j_q);
          l_out_d  = s_sat;
        end
        if (j_q != LAST_C) begin
          j_d     = j_q + 1'b1;
          state_d = S_R_J;
        end else begin
          j_d     = '0;
          i_d     = i_nxt;
          k_d     = k_nxt;
          a_d     = '0;
          state_d = relax_end ? S_CO_ST : S_R_IK;
        end
      end
      S_CO_ST: begin
        l_en_d   = 1'b1;
        l_addr_d = a_q;
        state_d  = S_CO_RD;
      end
      S_CO_RD: state_d = S_CO_CAP;
      S_CO_CAP: begin
        p_en_d   = 1'b1;
        p_we_d   = 1'b1;
        p_addr_d = a_q;
        p_out_d  = L_In;
        if (a_q == LAST_A) begin
          state_d = S_CO_FIN;
        end else begin
          a_d      = a_q + 1'b1;
          l_en_d   = 1'b1;
          l_addr_d = a_q + 1'b1;
          state_d  = S_CO_RD;
        end
      end
      S_CO_FIN: begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered memory-port outputs
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      k_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      dik_q    <= '0;
      dkj_q    <= '0;
      m_en_q   <= 1'b0;
      m_addr_q <= '0;
      l_en_q   <= 1'b0;
      l_we_q   <= 1'b0;
      l_addr_q <= '0;
      l_out_q  <= '0;
      p_en_q   <= 1'b0;
      p_we_q   <= 1'b0;
      p_addr_q <= '0;
      p_out_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      k_q      <= k_d;
      i_q      <= i_d;
      j_q      <= j_d;
      dik_q    <= dik_d;
      dkj_q    <= dkj_d;
      m_en_q   <= m_en_d;
      m_addr_q <= m_addr_d;
      l_en_q   <= l_en_d;
      l_we_q   <= l_we_d;
      l_addr_q <= l_addr_d;
      l_out_q  <= l_out_d;
      p_en_q   <= p_en_d;
      p_we_q   <= p_we_d;
      p_addr_q <= p_addr_d;
      p_out_q  <= p_out_d;
      done_q   <= done_d;
    end
  end

  assign M_En   = m_en_q;
  assign M_We   = 1'b0;
  assign M_Addr = m_addr_q;
  assign L_En   = l_en_q;
  assign L_We   = l_we_q;
  assign L_Addr = l_addr_q;
  assign L_Out  = l_out_q;
  assign P_En   = p_en_q;
  assign P_We   = p_we_q;
  assign P_Addr = p_addr_q;
  assign P_Out  = p_out_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_shortest_path_4.sv
// Bench for shortest_path_4 with an 8-node graph. SRAM A ports are modelled
// here; expected P writes are queued when a run starts and a monitor pops and
// compares them as the DUT writes P.
module tb_shortest_path_4;
  localparam int N   = 8;
  localparam int AW  = 13;
  localparam int NN  = N * N;
  localparam int MEM = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          go  = 1'b0;
  logic [7:0]    L_In, M_In, L_Out, P_Out;
  logic [AW-1:0] M_Addr, L_Addr, P_Addr;
  logic          M_En, M_We, L_En, L_We, P_En, P_We, Done;

  always #5 clk = ~clk;

  shortest_path_4 #(.N(N), .A_WIDTH(AW), .D_WIDTH(8), .INF(8'hFF)) dut (
    .Clk(clk), .Rst(rst), .Go(go), .L_In(L_In), .M_In(M_In),
    .L_Out(L_Out), .P_Out(P_Out), .M_Addr(M_Addr), .L_Addr(L_Addr),
    .P_Addr(P_Addr), .M_En(M_En), .M_We(M_We), .L_En(L_En), .L_We(L_We),
    .P_En(P_En), .P_We(P_We), .Done(Done)
  );

  logic [7:0] m_mem [MEM];
  logic [7:0] l_mem [MEM];
  logic [7:0] p_mem [MEM];
  logic [7:0] m_rd = 8'h00;
  logic [7:0] l_rd = 8'h00;
  logic       p_fill = 1'b0;

  always @(posedge clk) begin
    if (M_En) m_rd <= m_mem[M_Addr];
    if (L_En) begin
      if (L_We) l_mem[L_Addr] <= L_Out;
      else      l_rd <= l_mem[L_Addr];
    end
    if (p_fill) begin
      for (int a = 0; a < MEM; a++) p_mem[a] <= 8'hA5;
    end else if (P_En && P_We) begin
      p_mem[P_Addr] <= P_Out;
    end
  end
  assign M_In = m_rd;
  assign L_In = l_rd;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] exp_m [NN];
  int         checks = 0;
  int         errors = 0;

  // Scoreboard monitor: every P write must match the next queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (P_En && P_We) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL p_write_unexpected got addr %0d data %02h required no write",
                 P_Addr, P_Out);
      end else begin
        e = sb_q.pop_front();
        if (P_Addr !== e.addr || P_Out !== e.data) begin
          errors++;
          $display("FAIL p_write got addr %0d data %02h required addr %0d data %02h",
                   P_Addr, P_Out, e.addr, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, act, req);
    end
  endtask

  task automatic new_graph();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        m_mem[i*N+j] = (i == j) ? 8'h00 : 8'hFF;
        exp_m[i*N+j] = (i == j) ? 8'h00 : 8'hFF;
      end
  endtask

  task automatic set_edge(input int i, input int j, input logic [7:0] w);
    m_mem[i*N+j] = w;
  endtask

  task automatic set_exp(input int i, input int j, input logic [7:0] v);
    exp_m[i*N+j] = v;
  endtask

  task automatic push_expected();
    for (int a = 0; a < NN; a++) sb_q.push_back({AW'(a), exp_m[a]});
  endtask

  task automatic pulse_go();
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!Done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, {31'd0, Done}, 32'd1);
  endtask

  task automatic run_graph(input string name);
    push_expected();
    pulse_go();
    wait_done(name);
    check({name, "_sb_drained"}, sb_q.size(), 32'd0);
  endtask

  task automatic count_traffic(input int cycles, output int hits);
    hits = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (M_En || L_En || P_En || L_We || P_We) hits++;
    end
  endtask

  initial begin
    int hits;
    // Reset values
    @(posedge clk);
    @(negedge clk);
    check("rst_done",   {31'd0, Done}, 32'd0);
    check("rst_m_en",   {31'd0, M_En}, 32'd0);
    check("rst_m_we",   {31'd0, M_We}, 32'd0);
    check("rst_l_en",   {31'd0, L_En}, 32'd0);
    check("rst_l_we",   {31'd0, L_We}, 32'd0);
    check("rst_p_en",   {31'd0, P_En}, 32'd0);
    check("rst_p_we",   {31'd0, P_We}, 32'd0);
    check("rst_m_addr", 32'(M_Addr), 32'd0);
    check("rst_l_addr", 32'(L_Addr), 32'd0);
    check("rst_p_addr", 32'(P_Addr), 32'd0);
    check("rst_l_out",  32'(L_Out), 32'd0);
    check("rst_p_out",  32'(P_Out), 32'd0);
    #1 rst = 1'b0;
    p_fill = 1'b1;
    @(posedge clk); #1 p_fill = 1'b0;
    count_traffic(10, hits);
    check("idle_no_access", hits, 32'd0);

    // Identity: no edges, diagonal zero
    new_graph();
    run_graph("identity");
    check("p_beyond_nn",  32'(p_mem[NN]), 32'hA5);
    check("p_4096",       32'(p_mem[4096]), 32'hA5);
    check("p_last",       32'(p_mem[MEM-1]), 32'hA5);

    // Saturation and 254/255 boundary
    new_graph();
    set_edge(0, 1, 8'd200); set_edge(1, 2, 8'd100);
    set_exp(0, 1, 8'd200);  set_exp(1, 2, 8'd100); set_exp(0, 2, 8'hFF);
    set_edge(3, 4, 8'd127); set_edge(4, 5, 8'd127); set_edge(5, 6, 8'd1);
    set_exp(3, 4, 8'd127);  set_exp(4, 5, 8'd127); set_exp(5, 6, 8'd1);
    set_exp(3, 5, 8'd254);  set_exp(4, 6, 8'd128); set_exp(3, 6, 8'hFF);
    run_graph("saturation");

    // Shortcut improved by a path, and one that is already best
    new_graph();
    set_edge(0, 1, 8'd120); set_edge(1, 2, 8'd100); set_edge(0, 2, 8'd250);
    set_exp(0, 1, 8'd120);  set_exp(1, 2, 8'd100);  set_exp(0, 2, 8'd220);
    set_edge(3, 4, 8'd10);  set_edge(4, 5, 8'd10);  set_edge(3, 5, 8'd5);
    set_exp(3, 4, 8'd10);   set_exp(4, 5, 8'd10);   set_exp(3, 5, 8'd5);
    run_graph("shortcut");

    // Chain 0->1->2->3
    new_graph();
    set_edge(0, 1, 8'd3); set_edge(1, 2, 8'd4); set_edge(2, 3, 8'd5);
    set_exp(0, 1, 8'd3);  set_exp(1, 2, 8'd4);  set_exp(2, 3, 8'd5);
    set_exp(0, 2, 8'd7);  set_exp(0, 3, 8'd12); set_exp(1, 3, 8'd9);
    set_exp(3, 0, 8'hFF);
    run_graph("chain");

    // Done held with no traffic, then Go restarts the same run
    hits = 0;
    repeat (5) begin
      @(negedge clk);
      check("done_hold", {31'd0, Done}, 32'd1);
      if (M_En || L_En || P_En || L_We || P_We) hits++;
    end
    check("done_no_access", hits, 32'd0);
    push_expected();
    pulse_go();
    @(negedge clk);
    check("done_cleared", {31'd0, Done}, 32'd0);
    wait_done("rerun");
    check("rerun_sb_drained", sb_q.size(), 32'd0);

    // Reset in the middle of RELAX
    pulse_go();
    repeat (1000) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_done", {31'd0, Done}, 32'd0);
    check("midrst_en",   {29'd0, M_En, L_En, P_En}, 32'd0);
    check("midrst_we",   {30'd0, L_We, P_We}, 32'd0);
    rst = 1'b0;
    count_traffic(20, hits);
    check("midrst_quiet", hits, 32'd0);
    run_graph("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
